// File: rtl/sap1_control_sequencer.sv
// SAP-1 control sequencer: T-state ring (T1..T6) advanced on the falling
// clock edge, combinational opcode x T-state decode into datapath controls,
// early end of instruction, halt and single-step support.
module sap1_control_sequencer #(
  parameter int VARIABLE_LEN = 1,
  parameter int OP_W         = 4
) (
  input  logic            CLK,
  input  logic            nCLR,
  input  logic [OP_W-1:0] IR_OP,
  input  logic            RUN,
  input  logic            STEP,
  output logic [5:0]      TSTATE,
  output logic            CP,
  output logic            EP,
  output logic            LM,
  output logic            CE,
  output logic            LI,
  output logic            EI,
  output logic            LA,
  output logic            EA,
  output logic            SU,
  output logic            EU,
  output logic            LB,
  output logic            LO,
  output logic            HALTED,
  output logic            INSTR_DONE
);

  typedef enum logic [5:0] {
    T_IDLE = 6'b000000,
    T1     = 6'b000001,
    T2     = 6'b000010,
    T3     = 6'b000100,
    T4     = 6'b001000,
    T5     = 6'b010000,
    T6     = 6'b100000
  } tstate_e;

  localparam logic [OP_W-1:0] OP_LDA = OP_W'(4'h0);
  localparam logic [OP_W-1:0] OP_ADD = OP_W'(4'h1);
  localparam logic [OP_W-1:0] OP_SUB = OP_W'(4'h2);
  localparam logic [OP_W-1:0] OP_OUT = OP_W'(4'hE);
  localparam logic [OP_W-1:0] OP_HLT = OP_W'(4'hF);

  // The ring register is kept as a raw vector so that corrupted (non one-hot)
  // values stay visible and can be recovered from.
  logic [5:0] tstate_q, tstate_d;
  logic       halted_q, halted_d;
  logic       step_prev_q, step_prev_d;
  logic       legal_s;
  logic       qualify_s;
  logic [5:0] last_s;

  // Final T-state of the current opcode; HLT always stops after T4.
  function automatic logic [5:0] last_state(input logic [OP_W-1:0] op);
    logic [5:0] r;
    if (op == OP_HLT) begin
      r = T4;
    end else if (VARIABLE_LEN == 0) begin
      r = T6;
    end else begin
      case (op)
        OP_LDA:         r = T5;
        OP_ADD, OP_SUB: r = T6;
        OP_OUT:         r = T4;
        default:        r = T3;
      endcase
    end
    return r;
  endfunction

  // State register: falling-edge update with asynchronous active-low clear.
  always_ff @(negedge CLK or negedge nCLR) begin
    if (!nCLR) begin
      tstate_q    <= T_IDLE;
      halted_q    <= 1'b0;
      step_prev_q <= 1'b0;
    end else begin
      tstate_q    <= tstate_d;
      halted_q    <= halted_d;
      step_prev_q <= step_prev_d;
    end
  end

  // Next-state: advance only on a qualifying edge, recover illegal encodings.
  always_comb begin
    tstate_d    = tstate_q;
    halted_d    = halted_q;
    step_prev_d = STEP;
    qualify_s   = RUN | (STEP & ~step_prev_q);
    last_s      = last_state(IR_OP);
    case (tstate_q)
      T_IDLE, T1, T2, T3, T4, T5, T6: legal_s = 1'b1;
      default:                        legal_s = 1'b0;
    endcase
    if (halted_q) begin
      tstate_d = T_IDLE;
    end else if (!legal_s) begin
      tstate_d = T_IDLE;
    end else if (qualify_s) begin
      if (tstate_q == T_IDLE) begin
        tstate_d = T1;
      end else if ((IR_OP == OP_HLT) && (tstate_q == T4)) begin
        tstate_d = T_IDLE;
        halted_d = 1'b1;
      end else if ((tstate_q == last_s) || (tstate_q == T6)) begin
        tstate_d = T1;
      end else begin
        case (tstate_q)
          T1:      tstate_d = T2;
          T2:      tstate_d = T3;
          T3:      tstate_d = T4;
          T4:      tstate_d = T5;
          T5:      tstate_d = T6;
          default: tstate_d = T_IDLE;
        endcase
      end
    end else begin
      tstate_d = tstate_q;
    end
  end

  // Control decode from the registered ring and the opcode only.
  always_comb begin
    CP = 1'b0; EP = 1'b0; LM = 1'b0; CE = 1'b0;
    LI = 1'b0; EI = 1'b0; LA = 1'b0; EA = 1'b0;
    SU = 1'b0; EU = 1'b0; LB = 1'b0; LO = 1'b0;
    case (tstate_q)
      T1: begin EP = 1'b1; LM = 1'b1; end
      T2: begin CP = 1'b1; end
      T3: begin CE = 1'b1; LI = 1'b1; end
      T4: begin
        case (IR_OP)
          OP_LDA, OP_ADD, OP_SUB: begin EI = 1'b1; LM = 1'b1; end
          OP_OUT:                 begin EA = 1'b1; LO = 1'b1; end
          default:                begin end
        endcase
      end
      T5: begin
        case (IR_OP)
          OP_LDA:         begin CE = 1'b1; LA = 1'b1; end
          OP_ADD, OP_SUB: begin CE = 1'b1; LB = 1'b1; end
          default:        begin end
        endcase
      end
      T6: begin
        case (IR_OP)
          OP_ADD:  begin EU = 1'b1; LA = 1'b1; end
          OP_SUB:  begin EU = 1'b1; LA = 1'b1; SU = 1'b1; end
          default: begin end
        endcase
      end
      default: begin end
    endcase
  end

  // Status outputs.
  always_comb begin
    TSTATE     = tstate_q;
    HALTED     = halted_q;
    INSTR_DONE = (tstate_q != T_IDLE) && (tstate_q == last_state(IR_OP));
  end

endmodule

// File: tb/tb_sap1_control_sequencer.sv
// Self-checking bench for sap1_control_sequencer: one variable-length and one
// fixed-length instance share stimulus; each is compared every cycle against
// a T-index model built from the instruction tables.
module tb_sap1_control_sequencer;

  logic       CLK = 1'b0;
  logic       nCLR;
  logic       RUN;
  logic       STEP;
  logic [3:0] IR_OP;

  // {TSTATE[5:0], CP,EP,LM,CE,LI,EI,LA,EA,SU,EU,LB,LO, HALTED, INSTR_DONE}
  wire [19:0] obs_a;
  wire [19:0] obs_b;

  int vecs = 0;
  int miss = 0;

  int m_t  [2];
  bit m_h  [2];
  bit m_sp [2];

  localparam logic [11:0] C_CP = 12'h800, C_EP = 12'h400, C_LM = 12'h200,
                          C_CE = 12'h100, C_LI = 12'h080, C_EI = 12'h040,
                          C_LA = 12'h020, C_EA = 12'h010, C_SU = 12'h008,
                          C_EU = 12'h004, C_LB = 12'h002, C_LO = 12'h001;

  sap1_control_sequencer #(.VARIABLE_LEN(1), .OP_W(4)) dut_a (
    .CLK(CLK), .nCLR(nCLR), .IR_OP(IR_OP), .RUN(RUN), .STEP(STEP),
    .TSTATE(obs_a[19:14]),
    .CP(obs_a[13]), .EP(obs_a[12]), .LM(obs_a[11]), .CE(obs_a[10]),
    .LI(obs_a[9]),  .EI(obs_a[8]),  .LA(obs_a[7]),  .EA(obs_a[6]),
    .SU(obs_a[5]),  .EU(obs_a[4]),  .LB(obs_a[3]),  .LO(obs_a[2]),
    .HALTED(obs_a[1]), .INSTR_DONE(obs_a[0])
  );

  sap1_control_sequencer #(.VARIABLE_LEN(0), .OP_W(4)) dut_b (
    .CLK(CLK), .nCLR(nCLR), .IR_OP(IR_OP), .RUN(RUN), .STEP(STEP),
    .TSTATE(obs_b[19:14]),
    .CP(obs_b[13]), .EP(obs_b[12]), .LM(obs_b[11]), .CE(obs_b[10]),
    .LI(obs_b[9]),  .EI(obs_b[8]),  .LA(obs_b[7]),  .EA(obs_b[6]),
    .SU(obs_b[5]),  .EU(obs_b[4]),  .LB(obs_b[3]),  .LO(obs_b[2]),
    .HALTED(obs_b[1]), .INSTR_DONE(obs_b[0])
  );

  always #5 CLK = ~CLK;

  // Index (1..6) of the last T-state of an opcode.
  function automatic int last_t(input logic [3:0] op, input bit vl);
    if (op == 4'hF) return 4;
    if (!vl) return 6;
    case (op)
      4'h0:       return 5;
      4'h1, 4'h2: return 6;
      4'hE:       return 4;
      default:    return 3;
    endcase
  endfunction

  // Instruction table: active controls for opcode op in T-state t.
  function automatic logic [11:0] ctl_bits(input logic [3:0] op, input int t);
    logic [11:0] c;
    c = 12'h000;
    if (t == 1) c = C_EP | C_LM;
    if (t == 2) c = C_CP;
    if (t == 3) c = C_CE | C_LI;
    if (t == 4 && (op == 4'h0 || op == 4'h1 || op == 4'h2)) c = C_EI | C_LM;
    if (t == 4 && op == 4'hE) c = C_EA | C_LO;
    if (t == 5 && op == 4'h0) c = C_CE | C_LA;
    if (t == 5 && (op == 4'h1 || op == 4'h2)) c = C_CE | C_LB;
    if (t == 6 && op == 4'h1) c = C_EU | C_LA;
    if (t == 6 && op == 4'h2) c = C_EU | C_LA | C_SU;
    return c;
  endfunction

  function automatic logic [19:0] exp_vec(input int k);
    logic [5:0] ts;
    logic       done;
    int t;
    t    = m_t[k];
    ts   = (t == 0) ? 6'b000000 : (6'b000001 << (t - 1));
    done = (t != 0) && (t == last_t(IR_OP, k == 0));
    return {ts, ctl_bits(IR_OP, t), m_h[k], done};
  endfunction

  // One qualifying-edge evaluation of the reference model.
  task automatic model_step(input int k);
    bit qual;
    qual    = RUN || (STEP && !m_sp[k]);
    m_sp[k] = STEP;
    if (!m_h[k] && qual) begin
      if (m_t[k] == 0) m_t[k] = 1;
      else if (IR_OP == 4'hF && m_t[k] == 4) begin m_t[k] = 0; m_h[k] = 1'b1; end
      else if (m_t[k] == last_t(IR_OP, k == 0) || m_t[k] == 6) m_t[k] = 1;
      else m_t[k] = m_t[k] + 1;
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin m_t[k] = 0; m_h[k] = 1'b0; m_sp[k] = 1'b0; end
  endtask

  // One falling edge; leaves time at negedge+1 for sampling.
  task automatic advance();
    @(negedge CLK);
    model_step(0);
    model_step(1);
    #1;
  endtask

  task automatic do_reset();
    nCLR = 1'b0;
    #1 model_reset();
    #2 nCLR = 1'b1;
  endtask

  task automatic test_reset();
    nCLR = 1'b0; RUN = 1'b0; STEP = 1'b0; IR_OP = 4'h0;
    model_reset();
    #3;
    vecs++; if (obs_a !== 20'h0) begin miss++; $display("FAIL reset_a got=%b exp=%b", obs_a, 20'h0); end
    vecs++; if (obs_b !== 20'h0) begin miss++; $display("FAIL reset_b got=%b exp=%b", obs_b, 20'h0); end
    RUN = 1'b1;
    #9;
    vecs++; if (obs_a !== 20'h0) begin miss++; $display("FAIL reset_held got=%b exp=%b", obs_a, 20'h0); end
    RUN = 1'b0;
    #2 nCLR = 1'b1;
    advance();
    vecs++; if (obs_a !== exp_vec(0)) begin miss++; $display("FAIL reset_idle got=%b exp=%b", obs_a, exp_vec(0)); end
  endtask

  task automatic test_lda();
    logic [5:0] seq [6] = '{6'b000001, 6'b000010, 6'b000100, 6'b001000, 6'b010000, 6'b000001};
    do_reset();
    IR_OP = 4'h0; RUN = 1'b1;
    for (int i = 0; i < 6; i++) begin
      advance();
      vecs++; if (obs_a !== exp_vec(0)) begin miss++; $display("FAIL lda_a cyc=%0d got=%b exp=%b", i, obs_a, exp_vec(0)); end
      vecs++; if (obs_b !== exp_vec(1)) begin miss++; $display("FAIL lda_b cyc=%0d got=%b exp=%b", i, obs_b, exp_vec(1)); end
      vecs++; if (obs_a[19:14] !== seq[i]) begin miss++; $display("FAIL lda_seq cyc=%0d got=%b exp=%b", i, obs_a[19:14], seq[i]); end
    end
  endtask

  task automatic test_sub();
    IR_OP = 4'h2; RUN = 1'b1;
    for (int i = 0; i < 6; i++) begin
      advance();
      vecs++; if (obs_a !== exp_vec(0)) begin miss++; $display("FAIL sub_a cyc=%0d got=%b exp=%b", i, obs_a, exp_vec(0)); end
      vecs++; if (obs_b !== exp_vec(1)) begin miss++; $display("FAIL sub_b cyc=%0d got=%b exp=%b", i, obs_b, exp_vec(1)); end
      if (i == 4) begin
        vecs++; if (obs_a[5:4] !== 2'b11) begin miss++; $display("FAIL sub_t6_su_eu got=%b exp=11", obs_a[5:4]); end
      end
    end
  endtask

  task automatic test_out_hlt();
    IR_OP = 4'hE; RUN = 1'b1;
    for (int i = 0; i < 4; i++) begin
      advance();
      vecs++; if (obs_a !== exp_vec(0)) begin miss++; $display("FAIL out_a cyc=%0d got=%b exp=%b", i, obs_a, exp_vec(0)); end
    end
    IR_OP = 4'hF;
    for (int i = 0; i < 4; i++) begin
      advance();
      vecs++; if (obs_a !== exp_vec(0)) begin miss++; $display("FAIL hlt_a cyc=%0d got=%b exp=%b", i, obs_a, exp_vec(0)); end
    end
    vecs++; if (obs_a[1] !== 1'b1) begin miss++; $display("FAIL hlt_halted got=%b exp=1", obs_a[1]); end
    for (int i = 0; i < 20; i++) begin
      RUN = 1'($urandom); STEP = ~STEP;
      advance();
      vecs++; if (obs_a !== exp_vec(0)) begin miss++; $display("FAIL halt_hold_a cyc=%0d got=%b exp=%b", i, obs_a, exp_vec(0)); end
      vecs++; if (obs_b !== exp_vec(1)) begin miss++; $display("FAIL halt_hold_b cyc=%0d got=%b exp=%b", i, obs_b, exp_vec(1)); end
    end
    do_reset();
    vecs++; if (obs_a[1] !== 1'b0) begin miss++; $display("FAIL halt_clear got=%b exp=0", obs_a[1]); end
  endtask

  task automatic test_fixed();
    do_reset();
    IR_OP = 4'hE; RUN = 1'b1; STEP = 1'b0;
    for (int i = 0; i < 8; i++) begin
      advance();
      vecs++; if (obs_b !== exp_vec(1)) begin miss++; $display("FAIL fixed_b cyc=%0d got=%b exp=%b", i, obs_b, exp_vec(1)); end
      vecs++; if (obs_a !== exp_vec(0)) begin miss++; $display("FAIL fixed_a cyc=%0d got=%b exp=%b", i, obs_a, exp_vec(0)); end
    end
  endtask

  task automatic test_step();
    do_reset();
    RUN = 1'b0; IR_OP = 4'h0; STEP = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i == 5) STEP = 1'b0;
      if (i == 6) STEP = 1'b1;
      advance();
      vecs++; if (obs_a !== exp_vec(0)) begin miss++; $display("FAIL step_a cyc=%0d got=%b exp=%b", i, obs_a, exp_vec(0)); end
    end
    vecs++; if (obs_a[19:14] !== 6'b000010) begin miss++; $display("FAIL step_count got=%b exp=000010", obs_a[19:14]); end
    STEP = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    IR_OP = 4'h1; RUN = 1'b1;
    for (int i = 0; i < 5; i++) advance();
    vecs++; if (obs_a !== exp_vec(0)) begin miss++; $display("FAIL mid_t5 got=%b exp=%b", obs_a, exp_vec(0)); end
    #1 nCLR = 1'b0;
    model_reset();
    #1;
    vecs++; if (obs_a !== 20'h0) begin miss++; $display("FAIL mid_reset got=%b exp=%b", obs_a, 20'h0); end
    #1 nCLR = 1'b1;
    advance();
    vecs++; if (obs_a !== exp_vec(0)) begin miss++; $display("FAIL mid_restart got=%b exp=%b", obs_a, exp_vec(0)); end
  endtask

  task automatic test_illegal();
    do_reset();
    RUN = 1'b0; STEP = 1'b0; IR_OP = 4'h0;
    force dut_a.tstate_q = 6'b000011;
    #1 release dut_a.tstate_q;
    #1;
    vecs++; if (obs_a !== {6'b000011, 14'h0}) begin miss++; $display("FAIL illegal_hold got=%b exp=%b", obs_a, {6'b000011, 14'h0}); end
    advance();
    m_t[0] = 0;
    vecs++; if (obs_a !== exp_vec(0)) begin miss++; $display("FAIL illegal_recover got=%b exp=%b", obs_a, exp_vec(0)); end
    RUN = 1'b1;
    advance();
    vecs++; if (obs_a !== exp_vec(0)) begin miss++; $display("FAIL illegal_resume got=%b exp=%b", obs_a, exp_vec(0)); end
  endtask

  task automatic test_random();
    logic [3:0] ops [6] = '{4'h0, 4'h1, 4'h2, 4'hE, 4'hF, 4'h7};
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 39) == 0 || (m_h[0] && m_h[1])) do_reset();
      if (m_t[0] <= 1) begin
        IR_OP = ops[$urandom_range(0, 5)];
        if (IR_OP == 4'h7) IR_OP = 4'($urandom);
      end
      RUN  = ($urandom_range(0, 3) != 0);
      STEP = 1'($urandom);
      advance();
      vecs++; if (obs_a !== exp_vec(0)) begin miss++; $display("FAIL rand_a cyc=%0d op=%h got=%b exp=%b", i, IR_OP, obs_a, exp_vec(0)); end
      vecs++; if (obs_b !== exp_vec(1)) begin miss++; $display("FAIL rand_b cyc=%0d op=%h got=%b exp=%b", i, IR_OP, obs_b, exp_vec(1)); end
    end
  endtask

  initial begin
    test_reset();
    test_lda();
    test_sub();
    test_out_hlt();
    test_fixed();
    test_step();
    test_reset_mid();
    test_illegal();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule

// File: doc/sap1_control_sequencer.md
Name: sap1_control_sequencer

Overview:
- Instruction-cycle controller for the SAP-1 datapath.
- Owns the T-state ring (T1..T6) and advances it on the falling clock edge.
- Decodes the IR opcode against the current T-state into the per-block control signals (PC, MAR, RAM, IR, A, ALU, B, OUT), ends each instruction early once it is complete, and supports halt and single-step operation.
- Sits between the instruction register and every datapath register-enable / bus-enable.

Parameters:
- VARIABLE_LEN, 1: 1 = each instruction ends after its last active T-state; 0 = every instruction runs the full T1..T6.
- OP_W, 4: opcode width taken from IR upper nibble.

Ports:
- CLK  input  1  system clock; sequencer updates on negedge, datapath latches on posedge.
- nCLR  input  1  reset, asynchronous, active-low.
- IR_OP  input  OP_W  opcode from instruction register (valid from T4).
- RUN  input  1  1 = free-run; 0 = single-step.
- STEP  input  1  step request, level-sampled on negedge; rising transition advances one T-state when RUN=0.
- TSTATE  output  6  one-hot ring: bit0=T1 .. bit5=T6; 000000 = idle/halted.
- CP, EP, LM, CE, LI, EI, LA, EA, SU, EU, LB, LO  output  1 each  active-high controls: PC count, PC enable, MAR load, RAM enable, IR load, IR enable, A load, A enable, subtract, ALU enable, B load, OUT load.
- HALTED  output  1  high once HLT is executed.
- INSTR_DONE  output  1  high during the final T-state of each instruction.

Behaviour:
- Reset (nCLR=0, async):
  - TSTATE=000000, HALTED=0, step-edge register=0.
  - All controls 0 while TSTATE=000000.
- State register updates on negedge CLK only.
  - Idle (000000, not halted) -> T1 on the next qualifying negedge.
  - A qualifying negedge is any negedge with RUN=1, or one where STEP=1 and registered previous STEP=0 while RUN=0.
  - Non-qualifying negedges hold TSTATE.
- Decoding: controls are a combinational decode of the registered TSTATE and IR_OP only. No other inputs feed the decode.
- Fetch, common to all opcodes:
  - T1: EP, LM.
  - T2: CP.
  - T3: CE, LI.
- Execute, T4..T6:
  - LDA 0000:
    - T4: EI, LM.
    - T5: CE, LA.
  - ADD 0001:
    - T4: EI, LM.
    - T5: CE, LB.
    - T6: EU, LA.
  - SUB 0010: as ADD, plus SU asserted in T6.
  - OUT 1110:
    - T4: EA, LO.
  - HLT 1111:
    - T4: no controls.
    - Next qualifying negedge: TSTATE=000000, HALTED=1.
  - Any other opcode: NOP, no controls in T4..T6.
- Last T-state when VARIABLE_LEN=1:
  - NOP: T3.
  - OUT, HLT: T4.
  - LDA: T5.
  - ADD/SUB: T6.
- Last T-state when VARIABLE_LEN=0: T6 for every opcode except HLT, which halts from T4 regardless.
- End of instruction:
  - INSTR_DONE=1 combinationally during the last T-state.
  - The following qualifying negedge loads T1.
  - Exception: HLT loads 000000 and sets HALTED.
- Halted:
  - TSTATE held at 000000, all controls 0, INSTR_DONE=0.
  - RUN and STEP are ignored; only nCLR exits.
- Illegal TSTATE (not one-hot, and not 000000): next negedge forces 000000, from which normal operation resumes. Controls are 0 during the illegal state.
- Reset mid-instruction: immediate return to 000000, controls drop the same instant, no instruction completes.
- RUN changing 1->0 mid-instruction: current state held until a STEP edge. 0->1 resumes on the next negedge.
- STEP held high: advances exactly once per 0->1 transition.

Test Plan:
- Reset then RUN=1, IR_OP=0000 (LDA), VARIABLE_LEN=1 -> TSTATE 000000, 000001, 000010, 000100, 001000, 010000, 000001. Controls per T-state: {EP,LM}, {CP}, {CE,LI}, {EI,LM}, {CE,LA}. INSTR_DONE high in T5.
- IR_OP=0010 (SUB), RUN=1 -> six T-states; T6 asserts EU, LA, SU; INSTR_DONE in T6; next state T1.
- IR_OP=1110 (OUT) -> T4 asserts EA, LO, INSTR_DONE. Then IR_OP=1111 (HLT) -> after T4, TSTATE=000000 and HALTED=1 held over 20 cycles of RUN and STEP toggling; nCLR pulse clears HALTED.
- VARIABLE_LEN=0, IR_OP=1110 -> T5 and T6 visited with all controls 0; INSTR_DONE only in T6.
- RUN=0 with STEP high for 5 cycles, then low, then high -> exactly two advances (000000->000001->000010); TSTATE holds between them.
- nCLR asserted mid-T5 of ADD, off-edge -> TSTATE=000000 and controls 0 immediately; after release, next negedge -> T1. Separately, force TSTATE=000011 -> next negedge 000000.
